// File: rtl/hack_cpu_core.sv
// Multicycle Hack CPU control/register stage.
// Holds A, D, PC and drives the external ALU and a req/ack data bus.
module hack_cpu_core (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] dbg_a,
  output logic [15:0] dbg_d,
  output logic [14:0] dbg_pc
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MREAD,
    S_EXEC,
    S_MWRITE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] a;
  logic [15:0] d;
  logic [14:0] pc;
  logic [15:0] ir;
  logic [15:0] m_reg;
  logic [15:0] r;
  logic [14:0] waddr;
  logic [14:0] next_pc;

  logic        is_c;
  logic        sel_m;
  logic        dst_a;
  logic        dst_d;
  logic        dst_m;
  logic        jump;
  logic [14:0] pc_inc;
  logic [14:0] pc_sel;

  assign is_c   = ir[15];
  assign sel_m  = ir[12];
  assign dst_a  = ir[5];
  assign dst_d  = ir[4];
  assign dst_m  = ir[3];
  assign pc_inc = pc + 15'd1;

  assign jump = (ir[2] & alu_ng)
              | (ir[1] & alu_zr)
              | (ir[0] & ~alu_zr & ~alu_ng);

  // Jump target is always the A value seen before this instruction's dA write.
  assign pc_sel = jump ? a[14:0] : pc_inc;

  assign rom_addr = pc;
  assign dbg_a    = a;
  assign dbg_d    = d;
  assign dbg_pc   = pc;

  assign alu_x  = d;
  assign alu_y  = sel_m ? m_reg : a;
  assign alu_zx = ir[11];
  assign alu_nx = ir[10];
  assign alu_zy = ir[9];
  assign alu_ny = ir[8];
  assign alu_f  = ir[7];
  assign alu_no = ir[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!is_c) begin
          state_nxt = S_FETCH;
        end else if (sel_m) begin
          state_nxt = S_MREAD;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_MREAD: begin
        if (mem_ack) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = dst_m ? S_MWRITE : S_FETCH;
      end
      S_MWRITE: begin
        if (mem_ack) begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Bus strobes come straight from the state register so reset kills them at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = a[14:0];
    mem_wdata = r;
    unique case (state)
      S_MREAD: begin
        mem_req = 1'b1;
      end
      S_MWRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = waddr;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a       <= '0;
      d       <= '0;
      pc      <= '0;
      ir      <= '0;
      m_reg   <= '0;
      r       <= '0;
      waddr   <= '0;
      next_pc <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          ir <= rom_data;
        end
        S_DECODE: begin
          if (!is_c) begin
            a  <= {1'b0, ir[14:0]};
            pc <= pc_inc;
          end
        end
        S_MREAD: begin
          if (mem_ack) begin
            m_reg <= mem_rdata;
          end
        end
        S_EXEC: begin
          waddr   <= a[14:0];
          r       <= alu_out;
          next_pc <= pc_sel;
          if (dst_a) begin
            a <= alu_out;
          end
          if (dst_d) begin
            d <= alu_out;
          end
          if (!dst_m) begin
            pc <= pc_sel;
          end
        end
        S_MWRITE: begin
          if (mem_ack) begin
            pc <= next_pc;
          end
        end
        default: begin
          ir <= ir;
        end
      endcase
    end
  end

endmodule
